// File: rtl/numeric_display_driver_pkg.sv
// Shared definitions for the numeric display driver.
// Provides the conversion FSM state type, the active-high glyph table
// ({g,f,e,d,c,b,a}) and a helper for the largest displayable value.
package numeric_display_driver_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_e;

  localparam logic [6:0] SegDash  = 7'b1000000;
  localparam logic [6:0] SegBlank = 7'b0000000;

  // Active-high glyph for one BCD digit; anything above 9 is blank.
  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b0111111;
      4'd1:    g = 7'b0000110;
      4'd2:    g = 7'b1011011;
      4'd3:    g = 7'b1001111;
      4'd4:    g = 7'b1100110;
      4'd5:    g = 7'b1101101;
      4'd6:    g = 7'b1111101;
      4'd7:    g = 7'b0000111;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1101111;
      default: g = SegBlank;
    endcase
    return g;
  endfunction

  // 10^digits - 1
  function automatic longint unsigned max_display(input int unsigned digits);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/numeric_display_driver_bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   start          1-cycle request; accepted only in idle
//   bin_in         binary value captured on an accepted start
//   busy           high in shift and done states (VALUE_W+1 cycles)
//   done           1-cycle pulse; bcd_out/overflow_pend are final during it
//   overflow_pend  captured value exceeds 10^DIGITS-1
//   bcd_out        BCD scratch register, DIGITS nibbles, digit 0 in [3:0]
module numeric_display_driver_bin_to_bcd
  import numeric_display_driver_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned VALUE_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_pend,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned     CntW   = $clog2(VALUE_W + 1);
  localparam longint unsigned MaxVal = max_display(DIGITS);

  conv_state_e            state_q, state_d;
  logic [VALUE_W-1:0]     bin_q;
  logic [4*DIGITS-1:0]    scratch_q;
  logic [4*DIGITS-1:0]    adj;
  logic [CntW-1:0]        cnt_q;
  logic                   ovf_q;

  // Add-3 correction on every nibble >= 5 before the shift.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StShift;
      end
      StShift: begin
        busy = 1'b1;
        if (cnt_q == CntW'(VALUE_W - 1)) state_d = StDone;
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        bin_q     <= bin_in;
        scratch_q <= '0;
        cnt_q     <= '0;
        ovf_q     <= (64'(bin_in) > MaxVal);
      end else if (state_q == StShift) begin
        {scratch_q, bin_q} <= {adj[4*DIGITS-2:0], bin_q, 1'b0};
        cnt_q              <= cnt_q + CntW'(1);
      end
    end
  end

  assign overflow_pend = ovf_q;
  assign bcd_out       = scratch_q;

endmodule

// File: rtl/numeric_display_driver.sv
// Multiplexed 7-segment driver: converts a binary value to BCD and scans
// DIGITS digits, advancing one digit per rising edge of scan_clk.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   scan_clk   slow divider output, synchronised and edge-detected as data
//   value      binary value, captured on load
//   load       1-cycle capture request, dropped while busy
//   busy       conversion in progress
//   overflow   displayed value exceeds 10^DIGITS-1 (all digits show '-')
//   seg        {g,f,e,d,c,b,a}, registered, polarity per ACTIVE_LOW
//   an         one-hot digit enable, registered, an[0] = least-significant
module numeric_display_driver
  import numeric_display_driver_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned VALUE_W       = 14,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_clk,
  input  logic [VALUE_W-1:0]  value,
  input  logic                load,
  output logic                busy,
  output logic                overflow,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                 conv_done;
  logic                 ovf_pend;
  logic [4*DIGITS-1:0]  bcd_new;

  logic [1:0]           sync_q;
  logic                 scan_prev_q;
  logic                 scan_tick;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]  disp_q, disp_d;
  logic                 ovf_q, ovf_d;
  logic [3:0]           nib;
  logic                 blank;
  logic [6:0]           glyph_d;
  logic [DIGITS-1:0]    an_d;
  logic [6:0]           seg_q;
  logic [DIGITS-1:0]    an_q;

  numeric_display_driver_bin_to_bcd #(
    .DIGITS  (DIGITS),
    .VALUE_W (VALUE_W)
  ) u_bin_to_bcd (
    .clk           (clk),
    .rst           (rst),
    .start         (load),
    .bin_in        (value),
    .busy          (busy),
    .done          (conv_done),
    .overflow_pend (ovf_pend),
    .bcd_out       (bcd_new)
  );

  assign scan_tick = sync_q[1] & ~scan_prev_q;

  // seg/an are built from next-state index and register so a tick and a
  // conversion completing together still give a coherent frame.
  always_comb begin
    idx_d  = idx_q;
    if (scan_tick) begin
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
    disp_d = conv_done ? bcd_new  : disp_q;
    ovf_d  = conv_done ? ovf_pend : ovf_q;

    nib   = disp_d[{idx_d, 2'b00} +: 4];
    // Blank digit i>0 when it and every more-significant digit are zero.
    blank = BLANK_LEADING && (idx_d != '0);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i >= int'(idx_d) && disp_d[4*i +: 4] != 4'd0) blank = 1'b0;
    end

    if (ovf_d)      glyph_d = SegDash;
    else if (blank) glyph_d = SegBlank;
    else            glyph_d = seg_glyph(nib);

    an_d = DIGITS'(1) << idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      scan_prev_q <= 1'b0;
      idx_q       <= '0;
      disp_q      <= '0;
      ovf_q       <= 1'b0;
      seg_q       <= ACTIVE_LOW ? ~seg_glyph(4'd0) : seg_glyph(4'd0);
      an_q        <= ACTIVE_LOW ? ~DIGITS'(1) : DIGITS'(1);
    end else begin
      sync_q      <= {sync_q[0], scan_clk};
      scan_prev_q <= sync_q[1];
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      ovf_q       <= ovf_d;
      seg_q       <= ACTIVE_LOW ? ~glyph_d : glyph_d;
      an_q        <= ACTIVE_LOW ? ~an_d : an_d;
    end
  end

  assign overflow = ovf_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_numeric_display_driver.sv
module tb_numeric_display_driver;

  localparam int DIGITS  = 4;
  localparam int VALUE_W = 14;

  // Active-low patterns as they appear on the seg pins.
  localparam logic [6:0] L0 = 7'h40, L1 = 7'h79, L2 = 7'h24, L3 = 7'h30, L4 = 7'h19;
  localparam logic [6:0] L5 = 7'h12, L6 = 7'h02, L7 = 7'h78, L8 = 7'h00, L9 = 7'h10;
  localparam logic [6:0] LB = 7'h7F, LD = 7'h3F;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               scan_clk = 1'b0;
  logic [VALUE_W-1:0] value = '0;
  logic               load = 1'b0;
  logic               busy;
  logic               overflow;
  logic [6:0]         seg;
  logic [DIGITS-1:0]  an;

  int total = 0;
  int bad = 0;
  int m_idx = 0;

  always #5 clk = ~clk;

  numeric_display_driver #(
    .DIGITS        (DIGITS),
    .VALUE_W       (VALUE_W),
    .ACTIVE_LOW    (1'b1),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scan_clk (scan_clk),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .overflow (overflow),
    .seg      (seg),
    .an       (an)
  );

  typedef struct {
    int unsigned      v;
    bit               ovf;
    logic [3:0][6:0]  segs;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] glyph_low(input int d);
    case (d)
      0: return L0; 1: return L1; 2: return L2; 3: return L3; 4: return L4;
      5: return L5; 6: return L6; 7: return L7; 8: return L8; default: return L9;
    endcase
  endfunction

  // Reference: digit i of v in decimal, with leading blanking and overflow dash.
  function automatic logic [6:0] model_seg(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (v > 9999) return LD;
    if (i > 0 && v < p) return LB;
    return glyph_low((v / p) % 10);
  endfunction

  // One full scan_clk period; the synchroniser delay fits well inside it.
  task automatic scan_edge();
    scan_clk = 1'b1;
    repeat (4) step();
    scan_clk = 1'b0;
    repeat (4) step();
    m_idx = (m_idx + 1) % DIGITS;
  endtask

  task automatic load_wait(input int v);
    int n;
    value = VALUE_W'(v);
    load  = 1'b1;
    step();
    load = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("conv_finishes", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_digits(input string tag, input logic [3:0][6:0] segs);
    for (int k = 0; k < DIGITS; k++) begin
      check({tag, "_an"}, {28'd0, an}, {28'd0, ~(4'b0001 << m_idx)});
      check({tag, "_seg"}, {25'd0, seg}, {25'd0, segs[m_idx]});
      scan_edge();
    end
  endtask

  initial begin
    int n;
    int err;
    logic [3:0][6:0] exp_segs;

    vecs[0] = '{1234,  1'b0, {L1, L2, L3, L4}};
    vecs[1] = '{7,     1'b0, {LB, LB, LB, L7}};
    vecs[2] = '{0,     1'b0, {LB, LB, LB, L0}};
    vecs[3] = '{10000, 1'b1, {LD, LD, LD, LD}};
    vecs[4] = '{9999,  1'b0, {L9, L9, L9, L9}};
    vecs[5] = '{1005,  1'b0, {L1, L0, L0, L5}};
    vecs[6] = '{50,    1'b0, {LB, LB, L5, L0}};
    vecs[7] = '{16383, 1'b1, {LD, LD, LD, LD}};
    vecs[8] = '{10,    1'b0, {LB, LB, L1, L0}};
    vecs[9] = '{8060,  1'b0, {L8, L0, L6, L0}};

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_an", {28'd0, an}, 32'h0000000E);
    check("rst_seg", {25'd0, seg}, 32'h00000040);

    // Busy length for a single conversion
    value = VALUE_W'(1234);
    load  = 1'b1;
    step();
    load = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    check("busy_len", n, 15);
    check_digits("v1234", vecs[0].segs);

    // Table-driven vectors
    foreach (vecs[i]) begin
      load_wait(vecs[i].v);
      check("tbl_ovf", {31'd0, overflow}, {31'd0, vecs[i].ovf});
      check_digits("tbl", vecs[i].segs);
    end

    // Loads at busy cycle 5 and in the DONE cycle are dropped
    value = VALUE_W'(1234);
    load  = 1'b1;
    step();
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) n++;
      load  = (c == 5 || c == 15);
      value = VALUE_W'(5678);
      step();
    end
    load = 1'b0;
    check("drop_busy_len", n, 15);
    check_digits("drop", vecs[0].segs);

    // Reset in the middle of a conversion
    value = VALUE_W'(4321);
    load  = 1'b1;
    step();
    load = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_idx = 0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ovf", {31'd0, overflow}, 32'd0);
    check("midrst_seg", {25'd0, seg}, {25'd0, L0});
    check_digits("midrst", vecs[2].segs);
    load_wait(1234);

    // Held scan_clk advances only once
    scan_clk = 1'b1;
    err = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (c >= 4 && an !== ~(4'b0001 << ((m_idx + 1) % DIGITS))) err++;
    end
    m_idx = (m_idx + 1) % DIGITS;
    scan_clk = 1'b0;
    repeat (4) step();
    check("hold_static", err, 0);

    // Eight periods: two wraps, always exactly one digit enabled
    err = 0;
    for (int p = 0; p < 8; p++) begin
      scan_clk = 1'b1;
      for (int c = 0; c < 4; c++) begin
        step();
        if ($countones(~an) != 1) err++;
      end
      scan_clk = 1'b0;
      for (int c = 0; c < 4; c++) begin
        step();
        if ($countones(~an) != 1) err++;
      end
      m_idx = (m_idx + 1) % DIGITS;
    end
    check("onehot", err, 0);
    check("wrap_an", {28'd0, an}, {28'd0, ~(4'b0001 << m_idx)});
    check("wrap_seg", {25'd0, seg}, {25'd0, model_seg(1234, m_idx)});

    // Randomised values against the decimal model
    for (int r = 0; r < 20; r++) begin
      int v;
      v = ($urandom % 4 == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 16383));
      load_wait(v);
      check("rnd_ovf", {31'd0, overflow}, {31'd0, (v > 9999)});
      for (int k = 0; k < DIGITS; k++) exp_segs[k] = model_seg(v, k);
      check_digits("rnd", exp_segs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
